// File: rtl/fusion_pkg.sv
// Shared types and widths for the fusion line packer and the DDR-side stages behind it.
package fusion_pkg;

  localparam int PIX_W        = 16;
  localparam int PIX_PER_WORD = 8;
  localparam int WORD_W       = PIX_W * PIX_PER_WORD;

  typedef enum logic [2:0] {
    WAIT_VS,
    WAIT_LINE,
    ACTIVE,
    FLUSH,
    EOL
  } pack_state_t;

endpackage

// File: rtl/fusion_out_reg.sv
// Single-entry valid/ready holding register. A word offered while the entry is
// occupied and not draining is dropped and raises the sticky ovf flag.
import fusion_pkg::*;

module fusion_out_reg #(
  parameter int W = WORD_W
) (
  input  logic         cmos1_pclk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  input  logic         out_ready,
  input  logic         ovf_clr,
  output logic         ovf
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge cmos1_pclk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (ovf_clr)
        ovf <= 1'b0;
      else if (in_valid && !in_ready)
        ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/fusion_line_packer.sv
// Packs the fused RGB565 stream into 128-bit frame-buffer words tagged with sof/eol.
// Build option FUSION_PACK_PAD_EN: zero-pad and emit the partial word at the end of short lines.
//
// state     | meaning
// WAIT_VS   | idle until a vsync rising edge starts a frame
// WAIT_LINE | frame open, waiting for the next href rising edge
// ACTIVE    | packing pixels into the lane register
// FLUSH     | partial padded word issued, closing the line
// EOL       | advance line_cnt, end the frame after line V_ACT-1
import fusion_pkg::*;

module fusion_line_packer #(
  parameter int H_ACT = 960,
  parameter int V_ACT = 540,
  parameter int LW    = 12
) (
  input  logic              cmos1_pclk,
  input  logic              rst,
  input  logic              fus_href,
  input  logic              fus_vsync,
  input  logic [PIX_W-1:0]  fus_data,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic [LW-1:0]     line_cnt,
  output logic              frame_done,
  output logic              ovf
);

  localparam int PW = WORD_W + 3;

  logic              href_q, href_d, vsync_q, vsync_d;
  logic [PIX_W-1:0]  data_q;
  pack_state_t       state;
  logic [2:0]        lane;
  logic [LW-1:0]     pix_cnt;
  logic [WORD_W-1:0] word_buf, cur_word;
  logic              sof_pending, eol_loaded;

  logic href_rise, href_fall, vs_rise, last_line;
  logic pix_en, full_done, flush_done;
  logic ld_valid, ld_ready, ld_eol, ld_last;
  logic [PW-1:0] ld_payload, held;
  logic out_last;

  always_ff @(posedge cmos1_pclk or negedge rst) begin
    if (!rst) begin
      href_q  <= 1'b0;
      href_d  <= 1'b0;
      vsync_q <= 1'b0;
      vsync_d <= 1'b0;
      data_q  <= '0;
    end else begin
      href_q  <= fus_href;
      href_d  <= href_q;
      vsync_q <= fus_vsync;
      vsync_d <= vsync_q;
      data_q  <= fus_data;
    end
  end

  assign href_rise = href_q & ~href_d;
  assign href_fall = ~href_q & href_d;
  assign vs_rise   = vsync_q & ~vsync_d;
  assign last_line = (line_cnt == LW'(V_ACT - 1));

  assign pix_en    = href_q && !vs_rise &&
                     ((state == ACTIVE) || (state == WAIT_LINE && href_rise));
  assign full_done = pix_en && (lane == 3'(PIX_PER_WORD - 1));

`ifdef FUSION_PACK_PAD_EN
  assign flush_done = (state == ACTIVE) && href_fall && (lane != '0) && !vs_rise;
`else
  assign flush_done = 1'b0;
`endif

  always_comb begin
    cur_word = word_buf;
    cur_word[lane*PIX_W +: PIX_W] = data_q;
  end

  // word_buf is cleared after every word, so a flushed word is already zero-filled
  assign ld_valid   = full_done | flush_done;
  assign ld_eol     = flush_done | (full_done && pix_cnt == LW'(H_ACT - 1));
  assign ld_last    = ld_eol & last_line;
  assign ld_payload = {ld_last, ld_eol, sof_pending, full_done ? cur_word : word_buf};

  fusion_out_reg #(.W(PW)) u_out_reg (
    .cmos1_pclk (cmos1_pclk),
    .rst        (rst),
    .in_valid   (ld_valid),
    .in_data    (ld_payload),
    .in_ready   (ld_ready),
    .out_valid  (out_valid),
    .out_data   (held),
    .out_ready  (out_ready),
    .ovf_clr    (vs_rise),
    .ovf        (ovf)
  );

  assign {out_last, out_eol, out_sof, out_data} = held;

  always_ff @(posedge cmos1_pclk or negedge rst) begin
    if (!rst) begin
      state       <= WAIT_VS;
      line_cnt    <= '0;
      lane        <= '0;
      pix_cnt     <= '0;
      word_buf    <= '0;
      sof_pending <= 1'b0;
      eol_loaded  <= 1'b0;
    end else if (vs_rise) begin
      state       <= WAIT_LINE;
      line_cnt    <= '0;
      lane        <= '0;
      pix_cnt     <= '0;
      word_buf    <= '0;
      sof_pending <= 1'b1;
      eol_loaded  <= 1'b0;
    end else begin
      if (ld_valid && ld_ready) begin
        sof_pending <= 1'b0;
        if (ld_eol)
          eol_loaded <= 1'b1;
      end
      if (pix_en) begin
        pix_cnt <= pix_cnt + 1'b1;
        if (full_done) begin
          lane     <= '0;
          word_buf <= '0;
        end else begin
          lane <= lane + 1'b1;
          word_buf[lane*PIX_W +: PIX_W] <= data_q;
        end
      end
      case (state)
        WAIT_VS: ;
        WAIT_LINE:
          if (href_rise) begin
            state      <= ACTIVE;
            eol_loaded <= 1'b0;
          end
        ACTIVE:
          if (href_fall) begin
            lane     <= '0;
            pix_cnt  <= '0;
            word_buf <= '0;
`ifdef FUSION_PACK_PAD_EN
            // flush word is issued on this edge so it lands two cycles after href falls
            state <= flush_done ? FLUSH : EOL;
`else
            state <= EOL;
`endif
          end
`ifdef FUSION_PACK_PAD_EN
        FLUSH: state <= EOL;
`endif
        EOL:
          if (last_line) begin
            state <= WAIT_VS;
          end else begin
            state    <= WAIT_LINE;
            line_cnt <= line_cnt + 1'b1;
          end
        default: state <= WAIT_VS;
      endcase
    end
  end

  // Normally fires on acceptance of the final eol word; the EOL-state term covers
  // a last line whose eol word was never produced or was dropped.
  always_ff @(posedge cmos1_pclk or negedge rst) begin
    if (!rst)
      frame_done <= 1'b0;
    else
      frame_done <= (out_valid && out_ready && out_last) ||
                    (state == EOL && last_line && !eol_loaded && !vs_rise);
  end

endmodule

// File: doc/fusion_line_packer.md
# fusion_line_packer

Downstream of the dual-camera fusion stage, in the cmos1_pclk domain. Takes the fused RGB565 pixel stream (href/vsync/16-bit data) and packs eight pixels into 128-bit words for the frame-buffer write FIFO. Tracks line and frame position and tags each word with start-of-frame and end-of-line. Flags overflow when the write side stalls.

## Interface
Parameters:
- H_ACT, 960: active pixels per line; must be a multiple of 8 unless padding is compiled in.
- V_ACT, 540: active lines per frame.
- LW, 12: width of the line and pixel counters.

Ports:
- cmos1_pclk  in  1  pixel clock; all logic runs on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- fus_href  in  1  fused line-valid; one pixel per cycle while high.
- fus_vsync  in  1  fused frame sync, active-high pulse between frames.
- fus_data  in  16  fused RGB565 pixel.
- out_data  out  128  packed word; pixel 0 in [15:0], pixel 7 in [127:112].
- out_valid  out  1  word valid.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both high.
- out_sof  out  1  qualifies out_valid; high on the first word of a frame.
- out_eol  out  1  qualifies out_valid; high on the last word of a line.
- line_cnt  out  LW  index of the current line (0..V_ACT-1).
- frame_done  out  1  one-cycle pulse after the last word of line V_ACT-1 is accepted.
- ovf  out  1  sticky overflow flag; cleared at the next vsync rising edge.

## Operation
- Input registers: fus_href, fus_vsync and fus_data are registered once. Edges of href and vsync are detected on the registered copies.
- State machine:
  - WAIT_VS: waits for the vsync rising edge. Reset lands here.
  - WAIT_LINE: on the vsync edge, clears line_cnt, sets the sof_pending flag and clears ovf. On an href rising edge, moves to ACTIVE.
  - ACTIVE: shifts pixels into the lane register and increments the 3-bit lane counter. When lane 7 is written, the word is complete.
  - On the href falling edge, goes to FLUSH if a partial word exists and padding is enabled; otherwise to EOL.
  - FLUSH: emits the partial word with the remaining lanes zero-filled, then goes to EOL.
  - EOL: line_cnt increments. If line_cnt reaches V_ACT-1, pulse frame_done and return to WAIT_VS; else return to WAIT_LINE.
- Output buffer: a single-entry output register.
  - A completed word loads the register if it is empty, or if it is being accepted in the same cycle.
  - Otherwise the new word is dropped and ovf is set. The held word is never overwritten.
- out_sof is set on the first word loaded after sof_pending, which then clears.
- out_eol is set on the word containing pixel H_ACT-1, or on the flushed word.
- A vsync rising edge in any state aborts the frame:
  - lane counter cleared; any partial word discarded;
  - state set to WAIT_LINE with a new frame started;
  - a word already held in the output register stays valid.
- href pulses beyond V_ACT lines are ignored until the next vsync.
- Reset mid-frame returns everything to reset values. The first frame after reset starts only at a vsync edge.

## Timing
- Reset values:
  - out_valid, out_sof, out_eol, frame_done, ovf = 0;
  - out_data = 0; line_cnt = 0;
  - state WAIT_VS.
- Latency: out_valid rises 2 cycles after the 8th pixel of a word is presented on fus_data (input register, then pack/load).
- out_data, out_sof and out_eol hold stable while out_valid=1 and out_ready=0.
- Sustained throughput is 1 word per 8 cycles. out_ready may stall for up to 7 consecutive cycles without overflow.
- Flush word (padding enabled): out_valid rises 2 cycles after href falls.
- frame_done: exactly one cycle wide, in the cycle after the final eol word is accepted.

## Configuration
- FUSION_PACK_PAD_EN defined:
  - lines whose length is not a multiple of 8 get a zero-padded final word, tagged out_eol;
  - the FLUSH state exists.
- FUSION_PACK_PAD_EN undefined:
  - FLUSH is compiled out; partial words at href fall are discarded;
  - out_eol is asserted only on the word completed by pixel H_ACT-1;
  - if href falls early, out_eol is never asserted for that line.

## Structure
- Shared package fusion_pkg holds:
  - the state enum (WAIT_VS, WAIT_LINE, ACTIVE, FLUSH, EOL);
  - PIX_W=16, PIX_PER_WORD=8, WORD_W=128.
- One sub-module, fusion_out_reg: the single-entry valid/ready holding register with the drop/ovf logic, reused by later DDR-side stages.

## Test plan
- Full frame with H_ACT=16, V_ACT=2, out_ready=1, pixel values 0..31: exactly 4 words.
  - word 0 = {16'h7..16'h0} with sof=1;
  - words 1 and 3 have eol=1;
  - one frame_done pulse.
- Backpressure: out_ready low for 7 cycles per word gives no ovf and all words intact. Holding it low for 9 cycles across a word boundary sets ovf=1; ovf clears at the next vsync rise.
- Short line of 12 pixels:
  - with FUSION_PACK_PAD_EN, the second word carries pixels 8..11 in [63:0], zeros above, eol=1;
  - without it, 1 word is emitted with eol=0.
- vsync asserted mid-line after 5 pixels: no partial word emitted, line_cnt=0, and the next word carries sof=1.
- rst asserted low during ACTIVE with out_valid=1: all outputs 0 immediately. Pixels are ignored until a vsync rising edge.
- Extra href line beyond V_ACT=2: no words, and no additional frame_done.
